// File: rtl/usrt_pkg.sv
// usrt_pkg: register offsets and STATUS bit positions shared across the USRT bridge.
package usrt_pkg;
    localparam logic [3:0] USRT_ADDR_DATA   = 4'h0;
    localparam logic [3:0] USRT_ADDR_STATUS = 4'h4;
    localparam int STATUS_EMPTY = 0;
    localparam int STATUS_FULL  = 1;
    localparam int STATUS_OVF   = 2;
endpackage

// File: rtl/usrt_fifo_mem.sv
// usrt_fifo_mem: DEPTH x 8 register array, one write port, one asynchronous read port, no reset.
module usrt_fifo_mem #(
    parameter int DEPTH = 8,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wAddr,
    input  logic [7:0]    wData,
    input  logic [AW-1:0] rAddr,
    output logic [7:0]    rData
);
    logic [7:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[wAddr] <= wData;
    assign rData = mem[rAddr];
endmodule

// File: rtl/usrt_tx_fifo.sv
// usrt_tx_fifo: APB-written transmit FIFO feeding the USRT serializer over valid/ready.
// Define USRT_TX_FIFO_OVF_EN to add the sticky overflow flag in STATUS.
module usrt_tx_fifo
    import usrt_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int ADDR_W = 8
) (
    input  logic              pClk,
    input  logic              pReset,
    input  logic              pSelect,
    input  logic              pEnable,
    input  logic              pWrite,
    input  logic [ADDR_W-1:0] pAddress,
    input  logic [7:0]        pWData,
    output logic [7:0]        pRData,
    output logic              pReady,
    output logic              pSlvErr,
    output logic [7:0]        txData,
    output logic              txValid,
    input  logic              txReady
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wrPtr, rdPtr;
    logic [CW-1:0] count;
    logic [3:0]    offset;
    logic [7:0]    status;
    logic access, isData, isStatus, empty, full, pop, dataWr, push, drop, ovf;
    logic unusedAddrBits;

    assign unusedAddrBits = ^pAddress[ADDR_W-1:4];
    assign offset   = pAddress[3:0];
    assign access   = pSelect & pEnable;
    assign isData   = offset == USRT_ADDR_DATA;
    assign isStatus = offset == USRT_ADDR_STATUS;
    assign empty    = count == '0;
    assign full     = count == CW'(DEPTH);
    assign pop      = !empty & txReady;
    assign dataWr   = access & pWrite & isData;
    // a pop in the same cycle frees the slot, so a write to a full FIFO still lands
    assign push     = dataWr & (!full | pop);
    assign drop     = dataWr & full & !pop;

    always_comb begin
        status = '0;
        status[STATUS_EMPTY] = empty;
        status[STATUS_FULL]  = full;
        status[STATUS_OVF]   = ovf;
    end

    assign pReady  = pReset & access;
    assign pSlvErr = pReady & pWrite & (drop | !(isData | isStatus));
    assign pRData  = (pReady & !pWrite) ? (isData ? 8'(count) : isStatus ? status : 8'h00) : 8'h00;
    assign txValid = !empty;

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop) rdPtr <= rdPtr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

`ifdef USRT_TX_FIFO_OVF_EN
    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) ovf <= 1'b0;
        else if (drop) ovf <= 1'b1;
        else if (access & !pWrite & isStatus) ovf <= 1'b0;
    end
`else
    assign ovf = 1'b0;
`endif

    usrt_fifo_mem #(.DEPTH(DEPTH)) mem (
        .clk(pClk),
        .we(push),
        .wAddr(wrPtr),
        .wData(pWData),
        .rAddr(rdPtr),
        .rData(txData)
    );
endmodule

// File: doc/usrt_tx_fifo.md
# usrt_tx_fifo

APB-side transmit buffer for the USRT bridge. It accepts bytes written over the AMBA APB bus, holds them in a small FIFO, and presents them one at a time to the USRT serializer with a valid/ready handshake. It also exposes a read-only status/level register on the same bus. It sits directly upstream of the serializer, between the APB decode and the transmit path.

## Interface
- DEPTH, 8, FIFO entries; power of two, 2..64
- ADDR_W, 8, width of pAddress used for decode
- pClk  in  1  system/APB clock; all logic on its rising edge
- pReset  in  1  asynchronous, active-low reset
- pSelect  in  1  APB slave select
- pEnable  in  1  APB access-phase strobe
- pWrite  in  1  APB direction; 1 = write
- pAddress  in  ADDR_W  APB byte address
- pWData  in  8  APB write data
- pRData  out  8  APB read data
- pReady  out  1  APB ready
- pSlvErr  out  1  APB error response
- txData  out  8  byte offered to the serializer
- txValid  out  1  txData holds a valid byte
- txReady  in  1  serializer accepts txData this cycle

## Operation
- Register map, decoded on pAddress[3:0]; upper bits ignored.
  - 0x0 DATA: a write pushes pWData. A read returns the level (count of stored bytes, 0..DEPTH).
  - 0x4 STATUS: read only. Bits are {5'b0, ovf, full, empty}.
  - Other offsets read as 0x00. Writes to them are ignored with pSlvErr=1.
- APB access:
  - The setup phase is pSelect & !pEnable.
  - The access phase is pSelect & pEnable. pReady=1 combinationally in every access phase (zero wait states).
  - A write commits on the access-phase clock edge only.
- Push:
  - A DATA write while not full stores the byte at the write pointer and increments the count.
  - A DATA write while full drops the byte and sets pSlvErr=1 for that access.
- Pop:
  - txValid = !empty.
  - txData = the entry at the read pointer (registered storage, no fall-through).
  - When txValid & txReady, the read pointer advances and the count decrements.
- Simultaneous push and pop in the same cycle:
  - Both take effect and the count is unchanged.
  - When full, the pop frees a slot in that same cycle, so the push is accepted.
  - When empty, txValid=0, so no pop occurs and only the push applies.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits.
- Reset (asynchronous, any time, including mid-transfer):
  - Pointers, count, ovf and stored validity all clear.
  - txValid=0, pRData=0, pSlvErr=0, pReady=0 while pReset is low.
  - Storage contents are don't-care.

## Timing
- Byte written in access cycle N: txValid=1 and txData valid from cycle N+1.
- Pop at edge N: the next entry is visible on txData in cycle N+1 (back-to-back pops allowed, 1 byte/cycle).
- pRData is combinational from the current state during the access phase and 0x00 otherwise.
- A read in the same access as a concurrent pop returns the pre-edge level.
- STATUS reflects the state before the current edge.

## Configuration
- USRT_TX_FIFO_OVF_EN defined:
  - A dropped write (push while full, without a simultaneous pop) sets sticky ovf.
  - A read of STATUS returns ovf=1 and clears ovf at that access edge.
- Not defined: ovf reads 0 and no ovf register exists. pSlvErr on full is unchanged.

## Structure
- Shared package usrt_pkg holds:
  - the register offset constants USRT_ADDR_DATA=4'h0 and USRT_ADDR_STATUS=4'h4;
  - the STATUS bit indices.
- One sub-module, usrt_fifo_mem: DEPTH x 8 register array with one write port and one asynchronous read port, no reset.

## Test plan
- Reset, then write 0xA5 to 0x0 → txValid=1 next cycle, txData=0xA5. Read 0x0 → 0x01. Read 0x4 → 0x00.
- With txReady=0, write 8 bytes 0x10..0x17 → STATUS=0x02, level read=0x08.
  - A 9th write, 0xFF → pSlvErr=1 and the byte is dropped.
  - With the macro defined, STATUS reads 0x06, then 0x02 on the next read.
- Full FIFO, then a write of 0x55 in the same cycle as txReady=1 → 0x10 popped, 0x55 accepted, pSlvErr=0, level stays 8, last byte out is 0x55.
- Hold txReady=1 while streaming 20 writes → bytes emerge in order across pointer wrap, and the final state has empty=1.
- Assert pReset low with 3 bytes stored → txValid drops immediately. After release, a level read returns 0x00.
- Write to 0x8 → pSlvErr=1 and the FIFO is unchanged. Read 0x8 → 0x00.
